// File: rtl/chip8_display_if.sv
// Bus between the CHIP-8 DXYN execution logic (master) and the sprite-row
// XOR engine (slave), carrying the draw request and the framebuffer images.
interface chip8_display_if;
  // draw is a single-cycle strobe with no back-pressure: every edge that
  // samples draw=1 performs one row XOR, so the engine has no ready signal.
  logic          draw;
  logic [5:0]    x;
  logic [4:0]    y;
  logic [3:0]    row_index;
  logic [7:0]    sprite_data;
  logic [2047:0] display_in;
  logic [2047:0] display_out;
  logic          collision;

  modport master (
    output draw, x, y, row_index, sprite_data, display_in,
    input  display_out, collision
  );

  modport slave (
    input  draw, x, y, row_index, sprite_data, display_in,
    output display_out, collision
  );
endinterface

// File: rtl/chip8_display.sv
// Registered sprite-row XOR engine for the 64x32 CHIP-8 framebuffer: one
// 8-pixel row is XORed into display_in per draw strobe, with a collision flag.
module chip8_display (
  input  logic             clk,
  input  logic             rst_n,
  chip8_display_if.slave   bus
);

  logic [5:0]    row_sum;
  logic [4:0]    row_sel;
  logic [5:0]    col_sel [8];
  logic [2047:0] next_image;
  logic          next_collision;

  // Row 0 / col 0 sits at bit 2047, so index = 2047 - {row, col} = ~{row, col}.
  assign row_sum = {1'b0, bus.y} + {2'b00, bus.row_index};
  assign row_sel = row_sum[4:0];

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      col_sel[k] = bus.x + 6'(k);
    end
  end

  always_comb begin
    next_image     = bus.display_in;
    next_collision = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.sprite_data[7-k]) begin
        next_image[~{row_sel, col_sel[k]}] = ~bus.display_in[~{row_sel, col_sel[k]}];
        next_collision = next_collision | bus.display_in[~{row_sel, col_sel[k]}];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.display_out <= '0;
      bus.collision   <= 1'b0;
    end else if (bus.draw) begin
      bus.display_out <= next_image;
      bus.collision   <= next_collision;
    end
  end

endmodule

// File: tb/tb_chip8_display.sv
// Self-checking bench for chip8_display: a reference model pushes expected
// images to a queue on each draw, popped and compared after the sampling edge.
module tb_chip8_display;

  localparam int W = 2049;  // {collision, display}

  logic clk;
  logic rst_n;
  chip8_display_if bus ();

  chip8_display dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [5:0] x, input logic [4:0] y,
                                         input logic [3:0] ri, input logic [7:0] sd,
                                         input logic [2047:0] din);
    logic [2047:0] d;
    logic coll;
    int r, c, idx;
    d    = din;
    coll = 1'b0;
    r    = (int'(y) + int'(ri)) % 32;
    for (int k = 0; k < 8; k++) begin
      c   = (int'(x) + k) % 64;
      idx = 2047 - (r * 64 + c);
      if (sd[7-k]) begin
        if (din[idx]) coll = 1'b1;
        d[idx] = ~d[idx];
      end
    end
    return {coll, d};
  endfunction

  function automatic logic [63:0] row_of(input logic [2047:0] img, input int r);
    return img[(31 - r) * 64 +: 64];
  endfunction

  task automatic compare_image(input string tag, input logic [W-1:0] e);
    check({tag, "_coll"}, 64'(bus.collision), 64'(e[2048]));
    for (int r = 0; r < 32; r++)
      check($sformatf("%s_row%0d", tag, r), row_of(bus.display_out, r), row_of(e[2047:0], r));
  endtask

  // driver: present one draw and leave draw high until the caller idles
  task automatic drive_draw(input logic [5:0] x, input logic [4:0] y, input logic [3:0] ri,
                            input logic [7:0] sd, input logic [2047:0] din, input string tag);
    @(negedge clk);
    bus.draw        = 1'b1;
    bus.x           = x;
    bus.y           = y;
    bus.row_index   = ri;
    bus.sprite_data = sd;
    bus.display_in  = din;
    exp_q.push_back(model(x, y, ri, sd, din));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 64'd1, 64'd0);
    end else begin
      last_exp = exp_q.pop_front();
      compare_image(tag, last_exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.draw = 1'b0;
  endtask

  function automatic logic [2047:0] rand_image();
    logic [2047:0] img;
    for (int i = 0; i < 64; i++) img[i*32 +: 32] = $urandom();
    return img;
  endfunction

  logic [2047:0] img;

  initial begin
    rst_n           = 1'b0;
    bus.draw        = 1'b0;
    bus.x           = '0;
    bus.y           = '0;
    bus.row_index   = '0;
    bus.sprite_data = '0;
    bus.display_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_disp", 64'(|bus.display_out), 64'd0);
    check("reset_coll", 64'(bus.collision), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic draw and erase
    drive_draw(6'd4, 5'd0, 4'd0, 8'hF0, '0, "t1");
    check("t1_nib", 64'(bus.display_out[2043:2040]), 64'hF);
    check("t1_row0", row_of(bus.display_out, 0), 64'h0F00_0000_0000_0000);
    img = bus.display_out;
    drive_draw(6'd4, 5'd0, 4'd0, 8'hF0, img, "t2");
    check("t2_zero", 64'(|bus.display_out), 64'd0);
    check("t2_coll", 64'(bus.collision), 64'd1);
    idle();

    // horizontal wrap
    drive_draw(6'd62, 5'd5, 4'd0, 8'hFF, '0, "hwrap");
    check("hwrap_row5", row_of(bus.display_out, 5), 64'hFC00_0000_0000_0003);
    // vertical wrap, back-to-back with the previous draw
    drive_draw(6'd0, 5'd31, 4'd1, 8'h81, '0, "vwrap");
    check("vwrap_2047", 64'(bus.display_out[2047]), 64'd1);
    check("vwrap_2040", 64'(bus.display_out[2040]), 64'd1);
    idle();

    // partial overlap, then empty sprite
    img = '0;
    img[2047 - (2 * 64 + 10)] = 1'b1;
    drive_draw(6'd8, 5'd2, 4'd0, 8'h20, img, "ovl");
    check("ovl_bit", 64'(bus.display_out[1909]), 64'd0);
    check("ovl_coll", 64'(bus.collision), 64'd1);
    drive_draw(6'd8, 5'd2, 4'd0, 8'h00, img, "zero");
    check("zero_coll", 64'(bus.collision), 64'd0);
    check("zero_bit", 64'(bus.display_out[1909]), 64'd1);
    idle();

    // randomized back-to-back draws over random images
    for (int i = 0; i < 20; i++) begin
      drive_draw(6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)),
                 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                 rand_image(), $sformatf("rnd%0d", i));
    end
    idle();

    // hold: display_in changes without draw are ignored
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.display_in  = rand_image();
      bus.sprite_data = 8'($urandom_range(1, 255));
      @(posedge clk);
      #1;
      compare_image($sformatf("hold%0d", i), last_exp);
    end

    // asynchronous reset between edges
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_disp", 64'(|bus.display_out), 64'd0);
    check("arst_coll", 64'(bus.collision), 64'd0);
    #1;
    rst_n = 1'b1;
    img = rand_image();
    drive_draw(6'd60, 5'd30, 4'd3, 8'hA5, img, "post_rst");
    idle();

    check("q_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chip8_display.md
Name: chip8_display

Overview:
- Registered sprite-row XOR engine for the CHIP-8 64x32 monochrome framebuffer.
- Each `draw` strobe XORs one 8-pixel sprite row into the supplied framebuffer image and registers the result.
- Also registers a collision flag: set when any lit pixel is turned off.
- Sits between the CHIP-8 DXYN execution logic, which iterates `row_index` over the sprite height, and the framebuffer storage.

Parameters:
- None. Geometry is fixed: 64 columns, 32 rows, 2048 pixels.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- draw  input  1  strobe: perform one sprite-row XOR on this clock edge
- x  input  6  sprite left column, 0..63
- y  input  5  sprite top row, 0..31
- row_index  input  4  sprite row offset added to y, 0..15
- sprite_data  input  8  sprite row pixels; bit 7 = leftmost pixel
- display_in  input  2048  current framebuffer image
- display_out  output  2048  registered framebuffer after the draw
- collision  output  1  registered: 1 if the last draw cleared at least one lit pixel

Behaviour:
- Pixel mapping:
  - Pixel (row r, col c) is bit index 2047 - (r*64 + c).
  - Row 0, col 0 is the MSB; each row is 64 contiguous bits, left column at the higher index.
- Target row: R = (y + row_index) mod 32.
  - Compute in at least 6 bits, then keep the low 5 bits.
  - Vertical wrap-around, no clipping.
- Target columns: for k = 0..7, C_k = (x + k) mod 64.
  - Horizontal wrap-around, no clipping.
  - sprite_data[7-k] maps to column C_k.
- On a rising clk edge with rst_n=1 and draw=1:
  - display_out <= display_in with bit(R, C_k) XORed by sprite_data[7-k] for k=0..7; all other bits copied unchanged from display_in.
  - collision <= OR over k of (display_in bit(R, C_k) AND sprite_data[7-k]).
- Latency: one cycle. Results are visible immediately after the edge that sampled draw=1.
- With draw=0, display_out and collision hold their values. display_in changes are ignored.
- Back-to-back draws (draw high on consecutive edges) are each processed independently against the display_in present at that edge.
  - Collision reflects only the most recent draw; it is not accumulated.
  - The caller accumulates VF across rows.
- sprite_data=0: display_out = display_in, collision=0.
- Reset: asserting rst_n=0 immediately (asynchronously) forces display_out to all zeros and collision to 0, including mid-sequence.
  - On the first edge after release, normal operation resumes.
- No combinational path from inputs to outputs. Both outputs are flops.

Test Plan:
- Reset, display_in=0, x=4, y=0, row_index=0, sprite_data=8'b11110000, one draw pulse:
  - Row 0 reads "....####" followed by 56 dots.
  - display_out[2043:2040]=4'hF, all other bits 0.
  - collision=0.
- Feed display_out back to display_in, repeat the same draw:
  - display_out all zeros.
  - collision=1.
- Horizontal wrap: display_in=0, x=62, y=5, row_index=0, sprite_data=8'hFF:
  - Row 5 columns 62, 63, 0..5 set, nothing else.
  - collision=0.
- Vertical wrap: display_in=0, x=0, y=31, row_index=1, sprite_data=8'h81:
  - Row 0 columns 0 and 7 set (bits 2047 and 2040).
  - collision=0.
- Partial overlap: display_in with only row 2 col 10 set; x=8, y=2, row_index=0, sprite_data=8'h20:
  - Bit cleared.
  - collision=1.
  - Next draw with sprite_data=0 gives collision=0 and display_out=display_in.
- Hold and reset:
  - Change display_in with draw=0 over several cycles: outputs unchanged.
  - Pulse rst_n low between clock edges: display_out=0 and collision=0 immediately, before the next edge.
